// File: rtl/ahb_lite_sram_slave_pkg.sv
// ahb_lite_sram_slave_pkg
//   Shared constants, state encoding and helpers for the AHB-Lite SRAM slave.
//   Contents: BUS_WIDTH, HTRANS/HSIZE/HRESP codes, FSM state type,
//   transfer legality check and byte-lane decode.
package ahb_lite_sram_slave_pkg;

  localparam int BUS_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // A transfer is legal when its size is at most a word and it is naturally aligned.
  function automatic logic size_addr_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian byte-lane enables for a legal transfer.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lanes = 4'b1111;
      default:    lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// ahb_lite_sram_slave_if
//   AHB-Lite slave-side bus bundle (one decoded HSEL line).
//   master modport: drives address/control/write data, observes responses.
//   slave modport : observes address/control/write data, drives responses.
interface ahb_lite_sram_slave_if;
  import ahb_lite_sram_slave_pkg::*;

  logic                 HSEL;
  logic [BUS_WIDTH-1:0] HADDR;
  logic [1:0]           HTRANS;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [BUS_WIDTH-1:0] HWDATA;
  logic                 HREADY;
  logic [BUS_WIDTH-1:0] HRDATA;
  logic                 HREADYOUT;
  logic                 HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_array.sv
// ahb_lite_sram_array
//   2^ADDR_BITS x 32 word storage, per-byte write enables.
//   i_clk   : write clock
//   i_we    : byte write enables (bit n writes bits 8n+7:8n)
//   i_addr  : word address, shared by the write and the read port
//   i_wdata : write data
//   o_rdata : asynchronous read data
//   Contents are not reset.
module ahb_lite_sram_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic [3:0]           i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);
  logic [31:0] r_mem [0:(1<<ADDR_BITS)-1];

  // Byte-masked synchronous write.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite responder in front of a word-organised SRAM.
//   HCLK   : bus clock
//   HRESET : synchronous active-high reset
//   bus    : slave modport (HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY in,
//            HRDATA/HREADYOUT/HRESP out)
//   ADDR_BITS   : log2 of depth in words; higher address bits alias.
//   WAIT_STATES : HREADYOUT-low cycles before every OKAY data phase.
module ahb_lite_sram_slave
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic HCLK,
  input  logic HRESET,
  ahb_lite_sram_slave_if.slave bus
);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [ADDR_BITS+1:0] r_addr;
  logic                 r_write;
  logic [2:0]           r_size;
  logic                 w_ready_st;
  logic                 w_accept;
  logic [3:0]           w_we;
  logic [31:0]          w_rdata;
  logic                 w_unused_bits;

  // The address phase is only sampled in states that present HREADYOUT=1.
  assign w_ready_st = (r_state == ST_IDLE) | (r_state == ST_DATA) | (r_state == ST_ERR2);
  assign w_accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1] & w_ready_st;

  assign w_unused_bits = ^{bus.HADDR[BUS_WIDTH-1:ADDR_BITS+2], bus.HTRANS[0]};

  // Next-state and wait counter decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_ERR1: begin
        w_state_nxt = ST_ERR2;
      end
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!w_accept) begin
          w_state_nxt = ST_IDLE;
        end else if (!size_addr_legal(bus.HSIZE, bus.HADDR[1:0])) begin
          w_state_nxt = ST_ERR1;
        end else if (WS_INIT == 4'd0) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = WS_INIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and address-phase capture.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= bus.HADDR[ADDR_BITS+1:0];
        r_write <= bus.HWRITE;
        r_size  <= bus.HSIZE;
      end else begin
        r_addr  <= r_addr;
        r_write <= r_write;
        r_size  <= r_size;
      end
    end
  end

  // A reset arriving on the closing edge of a write data phase discards the write.
  assign w_we = (r_state == ST_DATA && r_write && !HRESET) ? byte_lanes(r_size, r_addr[1:0])
                                                           : 4'b0000;

  ahb_lite_sram_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_addr  (r_addr[ADDR_BITS+1:2]),
    .i_wdata (bus.HWDATA),
    .o_rdata (w_rdata)
  );

  assign bus.HREADYOUT = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
  assign bus.HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA    = (r_state == ST_DATA && !r_write) ? w_rdata : 32'h0000_0000;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
module tb_ahb_lite_sram_slave;
  import ahb_lite_sram_slave_pkg::*;

  typedef struct packed {
    logic        hsel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        HCLK;
  logic        HRESET;
  logic        sel3;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd;
  xfer_t q[$];

  logic [7:0] mem_m   [2][4096];
  bit         known_m [2][4096];

  ahb_lite_sram_slave_if if0 ();
  ahb_lite_sram_slave_if if3 ();

  assign if0.HSEL   = hsel & ~sel3;
  assign if3.HSEL   = hsel & sel3;
  assign if0.HADDR  = haddr;
  assign if3.HADDR  = haddr;
  assign if0.HTRANS = htrans;
  assign if3.HTRANS = htrans;
  assign if0.HWRITE = hwrite;
  assign if3.HWRITE = hwrite;
  assign if0.HSIZE  = hsize;
  assign if3.HSIZE  = hsize;
  assign if0.HWDATA = hwdata;
  assign if3.HWDATA = hwdata;
  assign if0.HREADY = hready;
  assign if3.HREADY = hready;

  assign hready      = sel3 ? if3.HREADYOUT : if0.HREADYOUT;
  assign hreadyout_o = hready;
  assign hresp_o     = sel3 ? if3.HRESP : if0.HRESP;
  assign hrdata_o    = sel3 ? if3.HRDATA : if0.HRDATA;

  ahb_lite_sram_slave #(.ADDR_BITS(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (if0)
  );

  ahb_lite_sram_slave #(.ADDR_BITS(10), .WAIT_STATES(3)) u_dut3 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (if3)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  function automatic xfer_t mk(input logic s, input logic [1:0] t, input logic w,
                               input logic [2:0] z, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.hsel = s; x.trans = t; x.write = w; x.size = z; x.addr = a; x.wdata = d;
    return x;
  endfunction

  // Reference rules: size up to 4 bytes, address a multiple of the size.
  function automatic bit model_legal(input logic [2:0] size, input logic [31:0] addr);
    int n;
    if (size > 3'd2) return 1'b0;
    n = 1 << size;
    return (addr % n) == 0;
  endfunction

  function automatic void model_write(input int di, input xfer_t x);
    int n, b;
    n = 1 << x.size;
    for (int k = 0; k < n; k++) begin
      b = int'(x.addr % 4096) + k;
      mem_m[di][b]   = x.wdata[8*(b%4) +: 8];
      known_m[di][b] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_read(input int di, input logic [31:0] addr);
    logic [31:0] w;
    int base;
    base = int'(addr % 4096) / 4 * 4;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_m[di][base+k];
    return w;
  endfunction

  function automatic logic [31:0] model_mask(input int di, input logic [31:0] addr);
    logic [31:0] m;
    int base;
    base = int'(addr % 4096) / 4 * 4;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = known_m[di][base+k] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Plays the queued transfers back to back on the selected slave, checking each data phase.
  task automatic run_q(input int ws, input int di);
    xfer_t cur;
    xfer_t prev;
    bit have_prev;
    bit from_q;
    bit acc, legal, exp_err;
    int waits, exp_waits;
    logic [31:0] exp_rd, mask;
    have_prev = 1'b0;
    prev = '0;
    while (q.size() > 0 || have_prev) begin
      if (q.size() > 0) begin
        cur = q.pop_front();
        from_q = 1'b1;
      end else begin
        cur = mk(1'b0, HTRANS_IDLE, 1'b0, 3'b000, 32'h0, 32'h0);
        from_q = 1'b0;
      end
      hsel   = cur.hsel;
      htrans = cur.trans;
      hwrite = cur.write;
      hsize  = cur.size;
      haddr  = cur.addr;
      hwdata = have_prev ? prev.wdata : 32'h0;
      @(negedge HCLK);
      if (have_prev) begin
        acc       = prev.hsel && prev.trans[1];
        legal     = model_legal(prev.size, prev.addr);
        exp_err   = acc && !legal;
        exp_waits = !acc ? 0 : (legal ? ws : 1);
        waits = 0;
        while (hreadyout_o !== 1'b1 && waits < 40) begin
          total++;
          if (hresp_o !== exp_err) begin
            bad++;
            $display("FAIL hresp_wait addr=%h got=%b want=%b", prev.addr, hresp_o, exp_err);
          end
          waits++;
          @(negedge HCLK);
        end
        total++;
        if (waits !== exp_waits) begin
          bad++;
          $display("FAIL wait_cycles addr=%h size=%0d got=%0d want=%0d", prev.addr, prev.size, waits, exp_waits);
        end
        total++;
        if (hresp_o !== exp_err) begin
          bad++;
          $display("FAIL hresp_final addr=%h got=%b want=%b", prev.addr, hresp_o, exp_err);
        end
        if (acc && legal && !prev.write) begin
          exp_rd = model_read(di, prev.addr);
          mask   = model_mask(di, prev.addr);
          last_rd = hrdata_o;
          total++;
          if ((hrdata_o & mask) !== (exp_rd & mask)) begin
            bad++;
            $display("FAIL read_data addr=%h got=%h want=%h mask=%h", prev.addr, hrdata_o, exp_rd, mask);
          end
        end else begin
          total++;
          if (hrdata_o !== 32'h0) begin
            bad++;
            $display("FAIL hrdata_zero addr=%h got=%h want=00000000", prev.addr, hrdata_o);
          end
        end
        if (acc && legal && prev.write) model_write(di, prev);
      end
      @(posedge HCLK);
      #1;
      prev = cur;
      have_prev = from_q;
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    total += 6;
    if (if0.HREADYOUT !== 1'b1) begin bad++; $display("FAIL reset_hreadyout0 got=%b want=1", if0.HREADYOUT); end
    if (if0.HRESP !== 1'b0) begin bad++; $display("FAIL reset_hresp0 got=%b want=0", if0.HRESP); end
    if (if0.HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata0 got=%h want=0", if0.HRDATA); end
    if (if3.HREADYOUT !== 1'b1) begin bad++; $display("FAIL reset_hreadyout3 got=%b want=1", if3.HREADYOUT); end
    if (if3.HRESP !== 1'b0) begin bad++; $display("FAIL reset_hresp3 got=%b want=0", if3.HRESP); end
    if (if3.HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata3 got=%h want=0", if3.HRDATA); end
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  task automatic test_sizes();
    sel3 = 1'b0;
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0010, 32'hDEADBEEF));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0));
    run_q(0, 0);
    total++;
    if (last_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rw got=%h want=deadbeef", last_rd); end
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h0000_0012, 32'h11A52233));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0));
    run_q(0, 0);
    total++;
    if (last_rd !== 32'hDEA5BEEF) begin bad++; $display("FAIL byte_write got=%h want=dea5beef", last_rd); end
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h0000_0010, 32'h99991234));
    q.push_back(mk(1'b1, HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0));
    run_q(0, 0);
    total++;
    if (last_rd !== 32'hDEA51234) begin bad++; $display("FAIL half_write got=%h want=dea51234", last_rd); end
  endtask

  task automatic test_error();
    sel3 = 1'b0;
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0013, 32'hFFFFFFFF));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, 3'b011,     32'h0000_0010, 32'h0BAD0BAD));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h0000_0011, 32'h55555555));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0));
    run_q(0, 0);
    total++;
    if (last_rd !== 32'hDEA51234) begin bad++; $display("FAIL error_no_write got=%h want=dea51234", last_rd); end
  endtask

  task automatic test_no_transfer();
    sel3 = 1'b0;
    q.push_back(mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0010, 32'h00000000));
    q.push_back(mk(1'b1, HTRANS_IDLE,   1'b1, HSIZE_WORD, 32'h0000_0010, 32'h11111111));
    q.push_back(mk(1'b1, HTRANS_BUSY,   1'b1, HSIZE_WORD, 32'h0000_0010, 32'h22222222));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_1010, 32'h0));
    run_q(0, 0);
    total++;
    if (last_rd !== 32'hDEA51234) begin bad++; $display("FAIL alias_idle got=%h want=dea51234", last_rd); end
  endtask

  task automatic test_wait_states();
    sel3 = 1'b1;
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0010, 32'hCAFEF00D));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h0000_1013, 32'h77000000));
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0));
    run_q(3, 1);
    total++;
    if (last_rd !== 32'h77FEF00D) begin bad++; $display("FAIL ws3_pipeline got=%h want=77fef00d", last_rd); end
  endtask

  task automatic test_reset_in_wait();
    int lows;
    sel3 = 1'b1;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h0000_0010;
    @(posedge HCLK);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'h12345678;
    @(negedge HCLK);
    lows = hreadyout_o ? 0 : 1;
    total++;
    if (lows !== 1) begin bad++; $display("FAIL wait_entered got=%0d want=1", lows); end
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    total += 3;
    if (hreadyout_o !== 1'b1) begin bad++; $display("FAIL rst_wait_hreadyout got=%b want=1", hreadyout_o); end
    if (hresp_o !== 1'b0) begin bad++; $display("FAIL rst_wait_hresp got=%b want=0", hresp_o); end
    if (hrdata_o !== 32'h0) begin bad++; $display("FAIL rst_wait_hrdata got=%h want=0", hrdata_o); end
    repeat (4) @(posedge HCLK);
    #1;
    q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0));
    run_q(3, 1);
    total++;
    if (last_rd !== 32'h77FEF00D) begin bad++; $display("FAIL rst_discard got=%h want=77fef00d", last_rd); end
  endtask

  task automatic test_random(input bit use3);
    int r, off, sz;
    logic [31:0] a;
    sel3 = use3;
    for (int k = 0; k < 16; k++) begin
      q.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(k*4), $urandom));
    end
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        q.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 1'b1, HSIZE_WORD, 32'h0, $urandom));
      end else if (r == 1) begin
        q.push_back(mk(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(int'($urandom_range(0, 15)) * 4), $urandom));
      end else begin
        sz = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
        off = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0 && sz <= 2) off = off / (1 << sz) * (1 << sz);
        a = 32'(int'($urandom_range(0, 15)) * 4096 + int'($urandom_range(0, 15)) * 4 + off);
        q.push_back(mk(1'b1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), 3'(sz), a, $urandom));
      end
    end
    run_q(use3 ? 3 : 0, use3 ? 1 : 0);
  endtask

  initial begin
    HRESET = 1'b1;
    sel3 = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_WORD; haddr = 32'h0; hwdata = 32'h0; last_rd = 32'h0;
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 4096; b++) begin
        mem_m[d][b] = 8'h00;
        known_m[d][b] = 1'b0;
      end
    end
    #1;
    test_reset();
    test_sizes();
    test_error();
    test_no_transfer();
    test_wait_states();
    test_reset_in_wait();
    test_random(1'b0);
    test_random(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder that consumes one HSEL line produced by the system address decoder.
- Serves a word-organised on-chip SRAM with a parameterised number of wait states.
- Supports byte, halfword and word accesses, little-endian.
- Returns the two-cycle ERROR response for illegal transfers. One instance sits behind each decoded 256 MB region.

Parameters:
ADDR_BITS, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB)
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15)

Ports:
HCLK  input  1  bus clock; all state changes on its rising edge
HRESET  input  1  synchronous reset, active-high
HSEL  input  1  slave select from the address decoder
HADDR  input  `BUS_WIDTH  address-phase address
HTRANS  input  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
HWRITE  input  1  1=write, 0=read
HSIZE  input  3  transfer size (000 byte, 001 half, 010 word)
HWDATA  input  `BUS_WIDTH  write data, valid in data phase
HREADY  input  1  bus-level ready (muxed HREADYOUT of the active slave)
HRDATA  output  `BUS_WIDTH  read data, valid when HREADYOUT=1 in a read data phase
HREADYOUT  output  1  this slave's ready
HRESP  output  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (HRESET=1 at an edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, captured address-phase registers cleared. Memory contents are not reset.
- Transfer accept: at an edge with HSEL & HREADY & HTRANS[1]=1, latch HADDR[ADDR_BITS+1:0], HWRITE, HSIZE.
- Address bits above ADDR_BITS+1 are ignored: the memory aliases within its region.
- IDLE/BUSY, or HSEL=0 with HREADY=1: no transfer. The next data phase is zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Illegal transfers (any one of these) give the ERROR response:
  - HSIZE > 010;
  - HSIZE=001 with HADDR[0]=1;
  - HSIZE=010 with HADDR[1:0]!=00.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Legal accept with WAIT_STATES=0 → DATA.
    - Legal accept with WAIT_STATES>0 → WAIT, counter=WAIT_STATES.
    - Illegal accept → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 1 → DATA.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes this cycle.
    - Write: byte lanes selected by HSIZE/addr[1:0] take HWDATA on the closing edge.
    - Read: HRDATA = mem[addr word] combinationally; the full word is driven regardless of size.
    - Next state: a new accept at this edge follows the IDLE rules; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1.
    - No memory write is performed for an erroring transfer.
    - A new accept at this edge is evaluated as from IDLE. The master normally drives IDLE here.
- Byte-lane enables: byte: lane addr[1:0]; half: lanes {addr[1],0}+0/1; word: all four.
- HRDATA = 0 except in DATA for a read.
- Back-to-back write A then read A: the read data phase returns the newly written data. The write commits at the edge that starts the read data phase.
- The address phase is not sampled while HREADY=0; pipelined transfers stall correctly during WAIT.
- Reset mid-transfer (WAIT/ERR1/DATA): abort immediately to IDLE outputs. A pending write is discarded.

Decomposition:
- Shared defines file: `BUS_WIDTH plus new constants:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE codes (BYTE/HALF/WORD);
  - HRESP codes (OKAY/ERROR).
- One sub-module, ahb_lite_sram_array: 2^ADDR_BITS x 32 storage with 4-bit byte write enable, synchronous write and asynchronous read.
- Lane generation and the FSM stay in the top.

Test Plan:
- Reset: HRESET=1 two cycles → HREADYOUT=1, HRESP=0, HRDATA=0.
- Write word 32'hDEADBEEF to 0x0000_0010, then read 0x0000_0010 back-to-back → HRDATA=32'hDEADBEEF in the read data phase; WAIT_STATES=0 means no HREADYOUT low.
- Write byte 8'hA5 (on HWDATA[23:16]) to 0x0000_0012, then read word 0x10 → 32'hDEA5BEEF. Write half 16'h1234 to 0x0000_0010 → read gives 32'hDEA51234.
- Word write to 0x0000_0013 → one cycle HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; memory at 0x10 unchanged (32'hDEA51234). HSIZE=011 gives the same result.
- WAIT_STATES=3, read 0x0000_0010 → HREADYOUT low exactly 3 cycles, then high with correct data. A following pipelined NONSEQ held during the wait is accepted only once HREADY=1.
- HSEL=0 or HTRANS=IDLE/BUSY cycles, and HRESET asserted in WAIT → no memory change; after a HRESET pulse outputs return to reset values next cycle. Alias check: 0x0000_1010 reads the same word as 0x0000_0010 (ADDR_BITS=10).
